irq_controller: RTL and testbench

Prioritised interrupt/exception controller that sequences the CPU's exception entry and return path. It sits between the peripheral/pipeline event sources (illegal instruction, ALU overflow, timer overflow, UART Rx ready, UART Tx ready) and the pipeline flush/EPC logic. It latches peripheral edges, applies a software mask, selects one source by fixed priority, and holds a request until the pipeline accepts it. It is configured through a small memory-mapped register window on the data-memory bus.

---
 rtl/irq_controller_pkg.sv | 24 ++
 rtl/irq_controller_prio.sv | 10 +
 rtl/irq_controller.sv | 124 ++++++++++++
 tb/tb_irq_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_controller_pkg.sv
// Shared constants and state encoding for the interrupt controller.
// Source indices double as priorities (0 is highest).
package irq_controller_pkg;
  localparam int NSRC = 5;
  localparam logic [NSRC-1:0] EXC_BITS = 5'b00011;
  localparam logic [31:0] BASE = 32'h4000_0030;

  localparam int SRC_ERRINST = 0;
  localparam int SRC_OVF     = 1;
  localparam int SRC_TCOVF   = 2;
  localparam int SRC_RXRDY   = 3;
  localparam int SRC_TXRDY   = 4;

  localparam logic [1:0] REG_PEND   = 2'd0;
  localparam logic [1:0] REG_MASK   = 2'd1;
  localparam logic [1:0] REG_CAUSE  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;
endpackage

// File: rtl/irq_controller_prio.sv
// Lowest-index-wins one-hot priority encoder.
// Isolates the lowest set bit with the two's-complement trick.
module prio_enc_onehot #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);
  assign o_gnt = i_req & (~i_req + N'(1));
endmodule

// File: rtl/irq_controller.sv
// Prioritised interrupt/exception controller with a 4-word
// register window; sequences request, service and return.
module irq_controller
  import irq_controller_pkg::*;
(
  input  logic            C,
  input  logic            R,
  input  logic [NSRC-1:0] src,
  input  logic            kernel,
  output logic            irq_req,
  output logic [NSRC-1:0] irq_cause,
  input  logic            irq_ack,
  input  logic            eret,
  input  logic [31:0]     addr,
  input  logic            rd,
  input  logic            wr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata
);
  state_t r_state, w_state_n;
  logic [NSRC-1:0] r_src_d, r_pend, r_mask, r_cause, r_icause;
  logic [NSRC-1:0] w_icause_n, w_rise, w_elig, w_win;
  logic [NSRC-1:0] w_clr, w_pend_n;
  logic r_ie, w_ie_n, r_req, w_req_n;
  logic [31:0] r_rdata, w_rdata_n;
  logic w_hit, w_wr_pend, w_wr_mask, w_wr_stat, w_take;
  logic w_unused;

  assign w_unused = ^{wdata[31:NSRC], addr[1:0]};

  assign w_hit     = addr[31:4] == BASE[31:4];
  assign w_wr_pend = wr & w_hit & (addr[3:2] == REG_PEND);
  assign w_wr_mask = wr & w_hit & (addr[3:2] == REG_MASK);
  assign w_wr_stat = wr & w_hit & (addr[3:2] == REG_STATUS);

  // Exceptions are level-sensitive; peripherals are edge-latched.
  assign w_rise = src & ~r_src_d & ~EXC_BITS;
  assign w_elig = (src & EXC_BITS) | (r_pend & r_mask);
  assign w_take = (r_state == REQ) & irq_ack & r_req;

  prio_enc_onehot #(.N(NSRC)) u_prio (
    .i_req (w_elig),
    .o_gnt (w_win)
  );

  always_comb begin
    w_state_n  = r_state;
    w_req_n    = 1'b0;
    w_icause_n = '0;
    w_ie_n     = w_wr_stat ? wdata[0] : r_ie;
    unique case (r_state)
      IDLE: begin
        if (r_ie && |w_elig && !kernel) begin
          w_state_n  = REQ;
          w_req_n    = 1'b1;
          w_icause_n = w_win;
        end
      end
      REQ: begin
        if (w_take) begin
          w_state_n = SERVICE;
          w_ie_n    = 1'b0;
        end else if (~|w_elig) begin
          w_state_n = IDLE;
        end else begin
          w_req_n    = ~kernel;
          w_icause_n = w_win;
        end
      end
      SERVICE: begin
        if (eret) begin
          w_ie_n    = 1'b1;
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // New edges win over same-cycle clears.
  assign w_clr = (w_wr_pend ? wdata[NSRC-1:0] : '0)
               | (w_take ? r_icause : '0);
  assign w_pend_n = ((r_pend & ~w_clr) | w_rise) & ~EXC_BITS;

  always_comb begin
    w_rdata_n = '0;
    if (rd && w_hit) begin
      case (addr[3:2])
        REG_PEND:  w_rdata_n = 32'(r_pend);
        REG_MASK:  w_rdata_n = 32'(r_mask);
        REG_CAUSE: w_rdata_n = 32'(r_cause);
        default:   w_rdata_n = {30'b0, r_state == SERVICE, r_ie};
      endcase
    end
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      r_state  <= IDLE;
      r_src_d  <= '0;
      r_pend   <= '0;
      r_mask   <= '0;
      r_cause  <= '0;
      r_icause <= '0;
      r_ie     <= 1'b1;
      r_req    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_n;
      r_src_d  <= src;
      r_pend   <= w_pend_n;
      r_icause <= w_icause_n;
      r_ie     <= w_ie_n;
      r_req    <= w_req_n;
      r_rdata  <= w_rdata_n;
      if (w_wr_mask) r_mask <= wdata[NSRC-1:0] & ~EXC_BITS;
      if (w_take) r_cause <= r_icause;
    end
  end

  assign irq_req   = r_req;
  assign irq_cause = r_icause;
  assign rdata     = r_rdata;
endmodule

// File: tb/tb_irq_controller.sv
// Directed plus randomized bench for irq_controller with a
// behavioural reference model checked every cycle.
module tb_irq_controller;
  import irq_controller_pkg::*;

  logic C = 1'b0;
  logic R = 1'b0;
  logic [4:0] src = '0;
  logic kernel = 1'b0, irq_ack = 1'b0, eret = 1'b0;
  logic rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic irq_req;
  logic [4:0] irq_cause;
  logic [31:0] rdata;

  int npass = 0;
  int ntotal = 0;

  irq_controller dut (
    .C(C), .R(R), .src(src), .kernel(kernel),
    .irq_req(irq_req), .irq_cause(irq_cause),
    .irq_ack(irq_ack), .eret(eret),
    .addr(addr), .rd(rd), .wr(wr),
    .wdata(wdata), .rdata(rdata)
  );

  always #5 C = ~C;

  // Reference model state
  bit [4:0] m_pend, m_mask, m_cause, m_icause, m_prev;
  bit m_ie, m_req, m_busy, m_asking;
  bit [31:0] m_rdata;

  function automatic bit [4:0] lowest(input bit [4:0] v);
    for (int i = 0; i < 5; i++)
      if (v[i]) return 5'(1 << i);
    return 5'd0;
  endfunction

  task automatic mreset();
    m_pend = 0; m_mask = 0; m_cause = 0; m_icause = 0;
    m_prev = 0; m_ie = 1; m_req = 0; m_busy = 0;
    m_asking = 0; m_rdata = 0;
  endtask

  task automatic model();
    bit [4:0] elig, win, npend;
    bit nie, hit;
    bit [31:0] rv;
    if (!R) begin
      mreset();
      return;
    end
    elig = (src & EXC_BITS) | (m_pend & m_mask);
    win = lowest(elig);
    hit = addr[31:4] == BASE[31:4];
    rv = 0;
    if (rd && hit) begin
      case (addr[3:2])
        2'd0: rv = 32'(m_pend);
        2'd1: rv = 32'(m_mask);
        2'd2: rv = 32'(m_cause);
        default: rv = {30'd0, m_busy, m_ie};
      endcase
    end
    npend = m_pend;
    nie = m_ie;
    if (wr && hit) begin
      case (addr[3:2])
        2'd0: npend = npend & ~wdata[4:0];
        2'd1: m_mask = wdata[4:0] & ~EXC_BITS;
        2'd3: nie = wdata[0];
        default: ;
      endcase
    end
    if (m_busy) begin
      if (eret) begin
        nie = 1;
        m_busy = 0;
      end
    end else if (m_asking) begin
      if (irq_ack && m_req) begin
        m_cause = m_icause;
        npend = npend & ~m_icause;
        nie = 0;
        m_busy = 1;
        m_asking = 0;
        m_req = 0;
        m_icause = 0;
      end else if (elig == 0) begin
        m_asking = 0;
        m_req = 0;
        m_icause = 0;
      end else begin
        m_req = !kernel;
        m_icause = win;
      end
    end else if (m_ie && elig != 0 && !kernel) begin
      m_asking = 1;
      m_req = 1;
      m_icause = win;
    end else begin
      m_req = 0;
      m_icause = 0;
    end
    m_pend = (npend | (src & ~m_prev)) & ~EXC_BITS;
    m_ie = nie;
    m_prev = src;
    m_rdata = rv;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge C);
    model();
    #1;
    chk("irq_req", 32'(irq_req), 32'(m_req));
    chk("irq_cause", 32'(irq_cause), 32'(m_icause));
    chk("rdata", rdata, m_rdata);
  endtask

  task automatic bus_wr(input int sel, input logic [31:0] d);
    addr = BASE + 32'(sel * 4);
    wdata = d;
    wr = 1;
    step();
    wr = 0;
  endtask

  task automatic bus_rd(input int sel, input logic [31:0] exp,
                        input string tag);
    addr = BASE + 32'(sel * 4);
    rd = 1;
    step();
    rd = 0;
    chk(tag, rdata, exp);
  endtask

  initial begin
    mreset();
    R = 0;
    repeat (2) step();
    R = 1;
    chk("reset_req", 32'(irq_req), 32'd0);
    bus_rd(0, 32'h0, "rst_pend");
    bus_rd(1, 32'h0, "rst_mask");
    bus_rd(2, 32'h0, "rst_cause");
    bus_rd(3, 32'h1, "rst_status");

    // Basic request / ack / return
    bus_wr(1, 32'h1c);
    src = 5'b01000;
    step();
    src = 0;
    step();
    chk("rx_req", 32'(irq_req), 32'd1);
    chk("rx_cause", 32'(irq_cause), 32'h08);
    irq_ack = 1;
    step();
    irq_ack = 0;
    bus_rd(2, 32'h8, "cause_rx");
    bus_rd(0, 32'h0, "pend_cleared");
    bus_rd(3, 32'h2, "status_svc");
    eret = 1;
    step();
    eret = 0;
    bus_rd(3, 32'h1, "status_ret");

    // Exception pre-empts pending peripheral
    src = 5'b10000;
    step();
    src = 0;
    step();
    chk("tx_cause", 32'(irq_cause), 32'h10);
    src = 5'b00001;
    step();
    chk("exc_cause", 32'(irq_cause), 32'h01);
    src = 0;
    step();
    chk("tx_back", 32'(irq_cause), 32'h10);
    irq_ack = 1;
    step();
    irq_ack = 0;
    eret = 1;
    step();
    eret = 0;

    // Kernel mode blocks requests
    kernel = 1;
    src = 5'b00100;
    step();
    src = 0;
    step();
    step();
    chk("kern_block", 32'(irq_req), 32'd0);
    kernel = 0;
    step();
    chk("kern_release", 32'(irq_req), 32'd1);
    irq_ack = 1;
    step();
    irq_ack = 0;
    eret = 1;
    step();
    eret = 0;

    // Same-cycle edge and W1C: set wins
    bus_wr(3, 32'h0);
    src = 5'b00100;
    bus_wr(0, 32'h4);
    src = 0;
    bus_rd(0, 32'h4, "set_wins");
    bus_wr(3, 32'h1);
    step();
    chk("req_before_rst", 32'(irq_req), 32'd1);

    // Async reset while requesting
    #2;
    R = 0;
    #1;
    mreset();
    chk("async_rst_req", 32'(irq_req), 32'd0);
    chk("async_rst_cause", 32'(irq_cause), 32'd0);
    step();
    R = 1;
    bus_wr(1, 32'h1c);
    step();
    step();
    chk("no_req_after_rst", 32'(irq_req), 32'd0);
    bus_rd(0, 32'h0, "rst2_pend");
    bus_rd(2, 32'h0, "rst2_cause");
    bus_rd(3, 32'h1, "rst2_status");

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      src = 5'($urandom & $urandom & $urandom);
      kernel = ($urandom % 8) == 0;
      irq_ack = ($urandom % 3) == 0;
      eret = ($urandom % 5) == 0;
      rd = ($urandom % 2) == 0;
      wr = ($urandom % 6) == 0;
      wdata = $urandom;
      if ($urandom % 8 == 0) addr = $urandom;
      else addr = BASE + 32'($urandom % 16);
      step();
    end
    rd = 0; wr = 0; src = 0; kernel = 0; irq_ack = 0; eret = 0;

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
